mult_fu: RTL
============

# mult_fu

Pipelined integer multiply functional unit sitting directly downstream of the reservation station's issue port. It accepts one issued multiply micro-op per cycle with resolved operand values, computes the RV32M product over `NUM_STAGES` pipeline stages, and presents the result with its ROB/PR tags as a CDB broadcast request. It drives the `busy` signal that the RS samples (as `rs_fu_in.mult_1` / `mult_2`) to decide whether a multiply may issue.

## Interface
- `XLEN`, 32: operand/result width.
- `NUM_STAGES`, 4: pipeline depth; legal values 1, 2, 4, 8 (must divide 64).
- `ROB_IDX_W`, `$clog2(`N_ROB_ENTRIES)`: ROB tag width.
- `PR_IDX_W`, `$clog2(`N_PHYS_REG)`: physical-register tag width.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low (0 = reset). One clock; reset is asynchronous and active-low.
- `start`  in  1  issue strobe from RS; sampled only when `busy` = 0.
- `opa`, `opb`  in  XLEN each  operand values (rs1, rs2).
- `func`  in  2  MULT_FUNC: MUL, MULH, MULHSU, MULHU.
- `rob_idx_in`  in  ROB_IDX_W  ROB tag.
- `pr_idx_in`  in  PR_IDX_W  destination physical register.
- `squash`  in  1  mispredict flush.
- `cdb_grant`  in  1  CDB arbiter accepts this cycle's request.
- `cdb_req`  out  1  result valid, requesting the CDB.
- `result`  out  XLEN  selected product half.
- `rob_idx_out`  out  ROB_IDX_W  ROB tag of the result.
- `pr_idx_out`  out  PR_IDX_W  physical-register tag of the result.
- `busy`  out  1  unit cannot accept `start` this cycle.

## Operation
- Operands are extended to 64 bits at entry: `opa` is sign-extended for MULH/MULHSU, zero-extended otherwise; `opb` is sign-extended for MULH only. The product is computed modulo 2^64.
- Each stage consumes `64/NUM_STAGES` bits of the multiplier, LSB chunk first. A stage adds (multiplicand × chunk) << offset to a 64-bit running sum and carries the multiplicand, the remaining multiplier, func, and tags.
- Result selection: MUL returns product[31:0]; all other ops return product[63:32].
- Each stage has a valid bit. The last stage is the output register: `cdb_req` = v[NUM_STAGES-1], and `result`/tags come from that stage.
- `stall = v[NUM_STAGES-1] & ~cdb_grant`. While stalled, every stage holds. Otherwise all stages shift by one and a bubble enters stage 0 unless a start is accepted.
- `busy = stall`. It is combinational only from `cdb_grant` and registered state; there is no path from `start`.
- A start is accepted iff `start & ~busy & ~squash`. `start` asserted while `busy` = 1 is dropped silently; the RS is responsible for not issuing then.
- `squash` clears all valid bits at the next edge (in-flight ops and the pending output). A simultaneous `start` is dropped. A simultaneous `cdb_grant` still counts as a completed broadcast for that cycle.

## Timing
- Reset values: all valid bits 0, data registers 0. Hence `cdb_req` = 0, `result` = 0, tags = 0, `busy` = 0. Reset asserts asynchronously; deassertion is synchronous to `clock`.
- Reset mid-operation discards every in-flight op; no partial broadcast follows.
- Latency: a start accepted at edge t yields `cdb_req` = 1 during the cycle after edge t+NUM_STAGES-1. With NUM_STAGES = 4, that is 4 cycles from the issue cycle to the request cycle.
- Throughput: one op per cycle while grants keep up.
- A request holds its `result` and tags stable until the cycle in which `cdb_grant` = 1. It drops at the next edge unless a following op shifts in.
- `cdb_grant` while `cdb_req` = 0 is ignored.

## Structure
- Shared package additions: `MULT_FUNC` enum (MUL = 0, MULH, MULHSU, MULHU), plus `XLEN`. `N_ROB_ENTRIES` and `N_PHYS_REG` come from the existing header.
- One sub-module, `mult_stage`: partial-product accumulate for one chunk, plus its valid/tag registers and hold enable. It is instantiated `NUM_STAGES` times in a generate loop.
- Top level contains only extension, the stall/busy logic, squash handling, and result selection.

## Test plan
- MUL, `opa` = 7, `opb` = 0xFFFFFFFD, grant held high → `cdb_req` 4 cycles after issue, `result` = 0xFFFFFFEB, tags echoed.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Back-to-back issue of 4 ops with `cdb_grant` = 0 → pipeline fills, `busy` = 1 from the cycle the first result appears. Raise grant for one cycle → exactly one broadcast, then `busy` follows the grant.
- `start` while `busy` = 1 → op is not captured; the broadcast count equals the accepted count.
- `squash` with 3 ops in flight plus a concurrent `start` → the next cycle has all valid bits 0, `cdb_req` = 0, `busy` = 0, and no later broadcast.
- Pull `reset` low asynchronously mid-stream → outputs go to 0 without a clock edge. After release, a fresh MUL 3 × 5 → `result` = 15 with nominal latency.

Source files
------------

// File: rtl/mult_fu_pkg.sv
// Shared definitions for the pipelined multiply functional unit.
package mult_fu_pkg;

    localparam int XLEN          = 32;
    localparam int PROD_W        = 2 * XLEN;
    localparam int N_ROB_ENTRIES = 32;
    localparam int N_PHYS_REG    = 64;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

endpackage

// File: rtl/mult_fu_stage.sv
// One multiply pipeline stage: accumulates one multiplier chunk into the running
// sum and carries the operands, func and tags along with a valid bit.
module mult_stage
    import mult_fu_pkg::*;
#(
    parameter int CHUNK_W   = 16,
    parameter int OFFSET    = 0,
    parameter int ROB_IDX_W = 5,
    parameter int PR_IDX_W  = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 hold_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [PROD_W-1:0]    mcand_i,
    input  logic [PROD_W-1:0]    mplier_i,
    input  logic [PROD_W-1:0]    sum_i,
    input  MULT_FUNC             func_i,
    input  logic [ROB_IDX_W-1:0] rob_i,
    input  logic [PR_IDX_W-1:0]  pr_i,
    output logic                 valid_o,
    output logic [PROD_W-1:0]    mcand_o,
    output logic [PROD_W-1:0]    mplier_o,
    output logic [PROD_W-1:0]    sum_o,
    output MULT_FUNC             func_o,
    output logic [ROB_IDX_W-1:0] rob_o,
    output logic [PR_IDX_W-1:0]  pr_o
);

    logic                 valid_q;
    logic [PROD_W-1:0]    mcand_q, mplier_q, sum_q;
    logic [PROD_W-1:0]    mplier_d, sum_d;
    MULT_FUNC             func_q;
    logic [ROB_IDX_W-1:0] rob_q;
    logic [PR_IDX_W-1:0]  pr_q;

    // Partial product of the lowest remaining chunk, placed at this stage's bit offset.
    always_comb begin
        sum_d    = sum_i + ((mcand_i * PROD_W'(mplier_i[CHUNK_W-1:0])) << OFFSET);
        mplier_d = mplier_i >> CHUNK_W;
    end

    // Valid bit clears on flush and otherwise follows upstream unless held; data only
    // loads when a real op enters so an emptied stage keeps its last contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sum_q    <= '0;
            func_q   <= MUL;
            rob_q    <= '0;
            pr_q     <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (!hold_i) begin
                valid_q <= valid_i;
            end
            if (!hold_i && valid_i) begin
                mcand_q  <= mcand_i;
                mplier_q <= mplier_d;
                sum_q    <= sum_d;
                func_q   <= func_i;
                rob_q    <= rob_i;
                pr_q     <= pr_i;
            end
        end
    end

    assign valid_o  = valid_q;
    assign mcand_o  = mcand_q;
    assign mplier_o = mplier_q;
    assign sum_o    = sum_q;
    assign func_o   = func_q;
    assign rob_o    = rob_q;
    assign pr_o     = pr_q;

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: operand extension, stall/busy control, squash and
// result-half selection around a chain of mult_stage instances.
module mult_fu
    import mult_fu_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int ROB_IDX_W  = $clog2(N_ROB_ENTRIES),
    parameter int PR_IDX_W   = $clog2(N_PHYS_REG)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [XLEN-1:0]      opa,
    input  logic [XLEN-1:0]      opb,
    input  MULT_FUNC             func,
    input  logic [ROB_IDX_W-1:0] rob_idx_in,
    input  logic [PR_IDX_W-1:0]  pr_idx_in,
    input  logic                 squash,
    input  logic                 cdb_grant,
    output logic                 cdb_req,
    output logic [XLEN-1:0]      result,
    output logic [ROB_IDX_W-1:0] rob_idx_out,
    output logic [PR_IDX_W-1:0]  pr_idx_out,
    output logic                 busy
);

    localparam int CHUNK_W = PROD_W / NUM_STAGES;

    // Index 0 is the entry point; index g+1 is the output of stage g.
    logic                 vld    [NUM_STAGES+1];
    logic [PROD_W-1:0]    mcand  [NUM_STAGES+1];
    logic [PROD_W-1:0]    mplier [NUM_STAGES+1];
    logic [PROD_W-1:0]    sum    [NUM_STAGES+1];
    MULT_FUNC             fn     [NUM_STAGES+1];
    logic [ROB_IDX_W-1:0] rob    [NUM_STAGES+1];
    logic [PR_IDX_W-1:0]  pr     [NUM_STAGES+1];

    logic stall;
    logic accept;

    // Sign-extend opa for MULH/MULHSU and opb for MULH only; everything else is unsigned.
    always_comb begin
        if (func == MULH || func == MULHSU) begin
            mcand[0] = {{(PROD_W-XLEN){opa[XLEN-1]}}, opa};
        end else begin
            mcand[0] = {{(PROD_W-XLEN){1'b0}}, opa};
        end
        if (func == MULH) begin
            mplier[0] = {{(PROD_W-XLEN){opb[XLEN-1]}}, opb};
        end else begin
            mplier[0] = {{(PROD_W-XLEN){1'b0}}, opb};
        end
    end

    // Whole pipe freezes while the output waits for the CDB; busy never looks at start.
    always_comb begin
        stall  = vld[NUM_STAGES] & ~cdb_grant;
        accept = start & ~stall & ~squash;
    end

    assign busy   = stall;
    assign vld[0] = accept;
    assign sum[0] = '0;
    assign fn[0]  = func;
    assign rob[0] = rob_idx_in;
    assign pr[0]  = pr_idx_in;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : gStage
        mult_stage #(
            .CHUNK_W  (CHUNK_W),
            .OFFSET   (g * CHUNK_W),
            .ROB_IDX_W(ROB_IDX_W),
            .PR_IDX_W (PR_IDX_W)
        ) uStage (
            .clock   (clock),
            .reset   (reset),
            .hold_i  (stall),
            .flush_i (squash),
            .valid_i (vld[g]),
            .mcand_i (mcand[g]),
            .mplier_i(mplier[g]),
            .sum_i   (sum[g]),
            .func_i  (fn[g]),
            .rob_i   (rob[g]),
            .pr_i    (pr[g]),
            .valid_o (vld[g+1]),
            .mcand_o (mcand[g+1]),
            .mplier_o(mplier[g+1]),
            .sum_o   (sum[g+1]),
            .func_o  (fn[g+1]),
            .rob_o   (rob[g+1]),
            .pr_o    (pr[g+1])
        );
    end

    // MUL returns the low word of the product, all other ops the high word.
    always_comb begin
        if (fn[NUM_STAGES] == MUL) begin
            result = sum[NUM_STAGES][XLEN-1:0];
        end else begin
            result = sum[NUM_STAGES][PROD_W-1:XLEN];
        end
    end

    assign cdb_req     = vld[NUM_STAGES];
    assign rob_idx_out = rob[NUM_STAGES];
    assign pr_idx_out  = pr[NUM_STAGES];

    logic [2*PROD_W-1:0] unused_tail;
    assign unused_tail = {mcand[NUM_STAGES], mplier[NUM_STAGES]};

endmodule
